// File: rtl/stepper_move_sequencer_if.sv
// Command channel between the CPU I/O decode and one stepper axis sequencer.
// The host drives target/valid/abort. The sequencer returns ready, which is high only while idle.
interface stepper_move_sequencer_if #(
  parameter int POS_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target;
  logic             cmd_abort;

  modport master (output cmd_valid, output cmd_target, output cmd_abort, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_target, input  cmd_abort, output cmd_ready);
endinterface

// File: rtl/stepper_move_sequencer.sv
// Unipolar stepper move sequencer.
// It accepts an absolute target and steps toward it once per divider tick.
// After arrival it holds the coils for a settle window, then pulses done.
// Build option HALF_STEP_EN: 8-entry half-step table instead of the 4-entry full-step table.
module stepper_move_sequencer #(
  parameter int CLK_DIV      = 160000,
  parameter int POS_W        = 16,
  parameter int SETTLE_TICKS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  stepper_move_sequencer_if.slave cmd,
  output logic [POS_W-1:0]        pos,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              coil
);

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STL_W = $clog2(SETTLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [STL_W-1:0] STL_MAX = STL_W'(SETTLE_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STL_W-1:0] stl_q, stl_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [3:0]       coil_q, coil_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             tick;

  // Coil pattern for a phase index, coil[3:0] written MSB first.
  function automatic logic [3:0] coil_pat(input logic [PH_W-1:0] ph);
`ifdef HALF_STEP_EN
    case (ph)
      3'd0:    coil_pat = 4'b1000;
      3'd1:    coil_pat = 4'b1100;
      3'd2:    coil_pat = 4'b0100;
      3'd3:    coil_pat = 4'b0110;
      3'd4:    coil_pat = 4'b0010;
      3'd5:    coil_pat = 4'b0011;
      3'd6:    coil_pat = 4'b0001;
      default: coil_pat = 4'b1001;
    endcase
`else
    case (ph)
      2'd0:    coil_pat = 4'b1100;
      2'd1:    coil_pat = 4'b0110;
      2'd2:    coil_pat = 4'b0011;
      default: coil_pat = 4'b1001;
    endcase
`endif
  endfunction

  assign tick = (cnt_q == CNT_MAX);

  // Next-state logic: handshake, stepping toward target, settle count, abort.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    stl_d   = stl_q;
    ph_d    = ph_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Abort has no effect here; ready is high, so valid alone accepts.
        if (cmd.cmd_valid) begin
          state_d = S_MOVE;
          tgt_d   = cmd.cmd_target;
          cnt_d   = '0;
        end
      end
      S_MOVE: begin
        if (cmd.cmd_abort) begin
          // A tick on the same edge is dropped; pos and phase stay where they are.
          state_d = S_IDLE;
          tgt_d   = pos_q;
          cnt_d   = '0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (pos_q < tgt_q) begin
              pos_d = pos_q + 1'b1;
              ph_d  = ph_q + 1'b1;
            end else if (pos_q > tgt_q) begin
              pos_d = pos_q - 1'b1;
              ph_d  = ph_q - 1'b1;
            end else begin
              state_d = S_SETTLE;
              stl_d   = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      S_SETTLE: begin
        if (cmd.cmd_abort) begin
          state_d = S_IDLE;
          tgt_d   = pos_q;
          cnt_d   = '0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (stl_q == STL_MAX) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              stl_d = stl_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state, so they line up with the state register.
    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_IDLE);
    coil_d = (state_d == S_IDLE) ? 4'b0000 : coil_pat(ph_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      stl_q   <= '0;
      ph_q    <= '0;
      coil_q  <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      stl_q   <= stl_d;
      ph_q    <= ph_d;
      coil_q  <= coil_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd.cmd_ready = rdy_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign done = done_q;
  assign coil = coil_q;

endmodule
